// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - pushbutton conditioner: sync, debounce, press/release one-shots
//
// Optional feature macro: REPETICAO_AUTO_EN (adds auto-repeat output and hold counters).
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   btn_n        raw active-low button levels, asynchronous to clock
//   enable       gates pulso/soltura (and repeticao); debounce keeps tracking when 0
//   pressionado  debounced level, active-high
//   pulso        one-cycle pulse on each accepted press
//   soltura      one-cycle pulse on each accepted release
//   repeticao    (REPETICAO_AUTO_EN only) auto-repeat pulses while a button is held

module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef REPETICAO_AUTO_EN
    ,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] btn_n,
    input  logic                enable,
    output logic [N_BOTOES-1:0] pressionado,
    output logic [N_BOTOES-1:0] pulso,
    output logic [N_BOTOES-1:0] soltura
`ifdef REPETICAO_AUTO_EN
    ,
    output logic [N_BOTOES-1:0] repeticao
`endif
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_BOTOES-1:0] sync1;
    logic [N_BOTOES-1:0] sync2;
    logic [N_BOTOES-1:0] amostra;
    logic [N_BOTOES-1:0] aceita;
    logic [CW-1:0]       cnt [N_BOTOES];

    // aceita marks the cycle in which a disagreeing sample has been seen
    // DEBOUNCE_CYCLES times in a row, i.e. the debounced level flips now.
    always_comb begin
        amostra = ~sync2;
        aceita  = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            aceita[i] = (amostra[i] != pressionado[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= '1;
            sync2       <= '1;
            pressionado <= '0;
            pulso       <= '0;
            soltura     <= '0;
            for (int i = 0; i < N_BOTOES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            pressionado <= pressionado ^ aceita;
            // Edge pulses coincide with the level flip; enable is looked at
            // only here, so a flip while disabled is simply not reported.
            pulso       <= aceita &  amostra & {N_BOTOES{enable}};
            soltura     <= aceita & ~amostra & {N_BOTOES{enable}};
            for (int i = 0; i < N_BOTOES; i++) begin
                if (amostra[i] == pressionado[i]) begin
                    cnt[i] <= '0;
                end else if (aceita[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef REPETICAO_AUTO_EN
    localparam int            HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            HW        = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0]       hcnt [N_BOTOES];
    logic [N_BOTOES-1:0] repetindo;
    logic [N_BOTOES-1:0] dispara;

    // The hold counter starts at zero on the pulso edge (pressionado was 0
    // until then) and first measures HOLD_CYCLES, then REPEAT_CYCLES periods.
    // A release being accepted this cycle suppresses any pulse.
    always_comb begin
        dispara = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            dispara[i] = pressionado[i] && !aceita[i] &&
                         (repetindo[i] ? (hcnt[i] == REP_LAST) : (hcnt[i] == HOLD_LAST));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            repeticao <= '0;
            repetindo <= '0;
            for (int i = 0; i < N_BOTOES; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            repeticao <= dispara & {N_BOTOES{enable}};
            for (int i = 0; i < N_BOTOES; i++) begin
                if (!pressionado[i] || aceita[i]) begin
                    hcnt[i]      <= '0;
                    repetindo[i] <= 1'b0;
                end else if (dispara[i]) begin
                    hcnt[i]      <= '0;
                    repetindo[i] <= 1'b1;
                end else begin
                    hcnt[i] <= hcnt[i] + HW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - table-driven bench for condicionador_botoes

module tb_condicionador_botoes;

    logic       clock;
    logic       reset;
    logic [3:0] btn_n;
    logic       enable;
    logic [3:0] pressionado;
    logic [3:0] pulso;
    logic [3:0] soltura;
`ifdef REPETICAO_AUTO_EN
    logic [3:0] repeticao;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    condicionador_botoes #(
        .N_BOTOES        (4),
        .DEBOUNCE_CYCLES (4)
`ifdef REPETICAO_AUTO_EN
        ,
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3)
`endif
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_n       (btn_n),
        .enable      (enable),
        .pressionado (pressionado),
        .pulso       (pulso),
        .soltura     (soltura)
`ifdef REPETICAO_AUTO_EN
        ,
        .repeticao   (repeticao)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] btn;
        logic [3:0] press;
        logic [3:0] pul;
        logic [3:0] sol;
    } vec_t;

    vec_t tab[$];

    task automatic add(input int n, input logic r, input logic e, input logic [3:0] b,
                       input logic [3:0] p, input logic [3:0] u, input logic [3:0] s);
        vec_t v;
        v.rst = r; v.en = e; v.btn = b; v.press = p; v.pul = u; v.sol = s;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] b);
        reset  = r;
        enable = e;
        btn_n  = b;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int first_rise;
        int n_pulses;
        reset  = 1'b1;
        enable = 1'b1;
        btn_n  = 4'b1111;

        // reset and idle
        add(20, 1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(10, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // channel 0: clean press and release
        add(5, 0, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1110, 4'b0001, 4'b0001, 4'b0000);
        add(4, 0, 1, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // channel 1: bounce 3 low / 1 high x5 never accepted, then held
        for (int r = 0; r < 5; r++) begin
            add(3, 0, 1, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
            add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        end
        add(5, 0, 1, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1101, 4'b0010, 4'b0010, 4'b0000);
        add(4, 0, 1, 4'b1101, 4'b0010, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b1111, 4'b0010, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0010);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // channel 2: press while disabled is lost, release enabled reported
        add(5, 0, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 0, 4'b1011, 4'b0100, 4'b0000, 4'b0000);
        add(2, 0, 0, 4'b1011, 4'b0100, 4'b0000, 4'b0000);
        add(3, 0, 1, 4'b1011, 4'b0100, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b1111, 4'b0100, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0100);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // channel 2: press enabled, release while disabled is lost
        add(5, 0, 1, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1011, 4'b0100, 4'b0100, 4'b0000);
        add(2, 0, 1, 4'b1011, 4'b0100, 4'b0000, 4'b0000);
        add(5, 0, 0, 4'b1111, 4'b0100, 4'b0000, 4'b0000);
        add(1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // channel 3: reset mid-hold, button still held afterwards
        add(5, 0, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b0111, 4'b1000, 4'b1000, 4'b0000);
        add(3, 0, 1, 4'b0111, 4'b1000, 4'b0000, 4'b0000);
        add(2, 1, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b0111, 4'b1000, 4'b1000, 4'b0000);
        add(2, 0, 1, 4'b0111, 4'b1000, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b1111, 4'b1000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1000);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // all channels simultaneously
        add(5, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        add(2, 0, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        add(5, 0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        add(2, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

        foreach (tab[i]) begin
            step(tab[i].rst, tab[i].en, tab[i].btn);
            check("pressionado", i, pressionado, tab[i].press);
            check("pulso",       i, pulso,       tab[i].pul);
            check("soltura",     i, soltura,     tab[i].sol);
        end

        // reset during debounce: progress discarded, press restarts after reset
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1110);
        step(0, 1, 4'b1110);
        step(1, 1, 4'b1110);
        check("rst_mid_press", 0, pressionado, 4'b0000);
        first_rise = -1;
        n_pulses   = 0;
        for (int j = 0; j < 15; j++) begin
            step(0, 1, 4'b1110);
            if (pulso[0]) begin
                n_pulses++;
                if (first_rise < 0) first_rise = j;
            end
        end
        check("rst_mid_first_pulse", 0, first_rise[3:0], 4'd5);
        check("rst_mid_pulse_count", 0, n_pulses[3:0], 4'd1);
        for (int j = 0; j < 10; j++) step(0, 1, 4'b1111);
        check("rst_mid_released", 0, pressionado, 4'b0000);

`ifdef REPETICAO_AUTO_EN
        // auto-repeat: pulso at j=5, repeats at pulso+8,+11,+14,+17,
        // release accepted at pulso+20 where a repeat would otherwise fall
        for (int j = 0; j < 36; j++) begin
            logic [3:0] exp_rep;
            logic [3:0] exp_press;
            logic [3:0] exp_sol;
            step(0, 1, (j < 20) ? 4'b1110 : 4'b1111);
            exp_rep   = (j == 13 || j == 16 || j == 19 || j == 22) ? 4'b0001 : 4'b0000;
            exp_press = (j >= 5 && j < 25) ? 4'b0001 : 4'b0000;
            exp_sol   = (j == 25) ? 4'b0001 : 4'b0000;
            check("repeticao",       j, repeticao,   exp_rep);
            check("rep_pressionado", j, pressionado, exp_press);
            check("rep_soltura",     j, soltura,     exp_sol);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
